// File: rtl/count7seg_mux.sv
// count7seg_mux: multi-digit BCD/hex up/down counter with a prescaled count
// step, synchronous load, and a time-multiplexed 7-segment display driver.

// One counter digit: increment/decrement step with carry/borrow chaining,
// plus load-value clamping for decimal mode.
module count7seg_mux_nib #(
  parameter int BCD = 1
) (
  input  logic [3:0] i_nib,
  input  logic       i_up,
  input  logic       i_cin,
  input  logic [3:0] i_ld,
  output logic [3:0] o_step,
  output logic [3:0] o_ld,
  output logic       o_cout
);
  localparam logic [3:0] MAX = (BCD != 0) ? 4'd9 : 4'd15;

  logic w_max, w_zero;

  // Step this digit only when the chain reaches it; carry/borrow out on roll.
  always_comb begin
    w_max  = (i_nib == MAX);
    w_zero = (i_nib == 4'd0);
    o_step = i_nib;
    o_cout = 1'b0;
    if (i_up) begin
      o_cout = i_cin & w_max;
      if (i_cin) o_step = w_max ? 4'd0 : 4'(i_nib + 4'd1);
    end else begin
      o_cout = i_cin & w_zero;
      if (i_cin) o_step = w_zero ? MAX : 4'(i_nib - 4'd1);
    end
    o_ld = ((BCD != 0) && (i_ld > 4'd9)) ? 4'd9 : i_ld;
  end
endmodule

module count7seg_mux #(
  parameter int DIGITS     = 4,
  parameter int TICK_DIV   = 50000,
  parameter int SCAN_DIV   = 500,
  parameter int BCD        = 1,
  parameter int LZB        = 1,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                  CLK,
  input  logic                  RES,
  input  logic                  EN,
  input  logic                  DIR,
  input  logic                  LOAD,
  input  logic [4*DIGITS-1:0]   LDVAL,
  input  logic [DIGITS-1:0]     DP,
  output logic [7:0]            Y,
  output logic [DIGITS-1:0]     AN,
  output logic [4*DIGITS-1:0]   CNT,
  output logic                  WRAP,
  output logic                  C
);
  localparam int   PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int   SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int   IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic AL = (ACTIVE_LOW != 0);

  logic [DIGITS-1:0][3:0] r_cnt, w_step, w_ld;
  logic [DIGITS:0]        w_carry;
  logic [DIGITS:0]        w_lz;
  logic [PW-1:0]          r_pre;
  logic [SW-1:0]          r_scan;
  logic [IW-1:0]          r_idx;
  logic                   r_wrap;
  logic [7:0]             r_y;
  logic [DIGITS-1:0]      r_an;
  logic                   w_pre_tc, w_tick, w_scan_tc, w_blank;
  logic [3:0]             w_nib;
  logic [6:0]             w_seg;
  logic [7:0]             w_y;
  logic [DIGITS-1:0]      w_an;

  // Least significant digit always steps; higher digits step on carry/borrow.
  assign w_carry[0]      = 1'b1;
  // A digit is a leading zero when it and every digit above it are zero.
  assign w_lz[DIGITS]    = 1'b1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_nib
    count7seg_mux_nib #(.BCD(BCD)) u_nib (
      .i_nib  (r_cnt[g]),
      .i_up   (DIR),
      .i_cin  (w_carry[g]),
      .i_ld   (LDVAL[4*g +: 4]),
      .o_step (w_step[g]),
      .o_ld   (w_ld[g]),
      .o_cout (w_carry[g+1])
    );
    assign w_lz[g] = (r_cnt[g] == 4'd0) & w_lz[g+1];
  end

  assign w_pre_tc  = (r_pre == PW'(TICK_DIV - 1));
  assign w_tick    = EN & w_pre_tc & ~LOAD;
  assign w_scan_tc = (r_scan == SW'(SCAN_DIV - 1));

  // Count prescaler: frozen by EN=0, restarted by a load.
  always_ff @(posedge CLK or negedge RES) begin
    if (!RES)          r_pre <= '0;
    else if (LOAD)     r_pre <= '0;
    else if (EN)       r_pre <= w_pre_tc ? '0 : PW'(r_pre + 1'b1);
  end

  // Counter and wrap pulse; load wins over a coincident tick.
  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      r_cnt  <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= w_tick & w_carry[DIGITS];
      if (LOAD)        r_cnt <= w_ld;
      else if (w_tick) r_cnt <= w_step;
    end
  end

  // Free-running scan divider stepping the selected digit.
  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      r_scan <= '0;
      r_idx  <= '0;
    end else if (w_scan_tc) begin
      r_scan <= '0;
      r_idx  <= (r_idx == IW'(DIGITS - 1)) ? '0 : IW'(r_idx + 1'b1);
    end else begin
      r_scan <= SW'(r_scan + 1'b1);
    end
  end

  // Segment decode of the selected digit, blanking and polarity.
  always_comb begin
    w_nib = r_cnt[r_idx];
    case (w_nib)
      4'h0: w_seg = 7'b1111110;
      4'h1: w_seg = 7'b0110000;
      4'h2: w_seg = 7'b1101101;
      4'h3: w_seg = 7'b1111001;
      4'h4: w_seg = 7'b0110011;
      4'h5: w_seg = 7'b1011011;
      4'h6: w_seg = 7'b1011111;
      4'h7: w_seg = 7'b1110000;
      4'h8: w_seg = 7'b1111111;
      4'h9: w_seg = 7'b1111011;
      4'hA: w_seg = 7'b1110111;
      4'hB: w_seg = 7'b0011111;
      4'hC: w_seg = 7'b1001110;
      4'hD: w_seg = 7'b0111101;
      4'hE: w_seg = 7'b1001111;
      4'hF: w_seg = 7'b1000111;
      default: w_seg = 7'b0000000;
    endcase
    w_blank = (LZB != 0) && (r_idx != '0) && w_lz[r_idx];
    w_y     = {(w_blank ? 7'b0000000 : w_seg), DP[r_idx]} ^ {8{AL}};
    w_an    = (DIGITS'(1) << r_idx) ^ {DIGITS{AL}};
  end

  // Display pin register; resets to digit 0 showing "0".
  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      r_y  <= 8'hFC ^ {8{AL}};
      r_an <= DIGITS'(1) ^ {DIGITS{AL}};
    end else begin
      r_y  <= w_y;
      r_an <= w_an;
    end
  end

  assign Y    = r_y;
  assign AN   = r_an;
  assign CNT  = r_cnt;
  assign WRAP = r_wrap;
  assign C    = AL;
endmodule

// File: tb/tb_count7seg_mux.sv
// Bench for count7seg_mux: four parameter variants share one stimulus stream
// and are checked every cycle against a numeric model of the counter/display.
module tb_count7seg_mux;
  logic        CLK = 1'b0;
  logic        RES = 1'b1;
  logic        EN = 1'b0, DIR = 1'b1, LOAD = 1'b0;
  logic [31:0] LDVAL = '0;
  logic [7:0]  DP = '0;

  always #5 CLK = ~CLK;

  logic [7:0]  y0, y1, y2, y3;
  logic [3:0]  an0, an1, an3;
  logic [1:0]  an2;
  logic [15:0] cnt0, cnt1, cnt3;
  logic [7:0]  cnt2;
  logic        wrap0, wrap1, wrap2, wrap3, c0, c1, c2, c3;

  count7seg_mux #(.DIGITS(4), .TICK_DIV(4), .SCAN_DIV(2), .BCD(1), .LZB(1), .ACTIVE_LOW(0)) u0 (
    .CLK(CLK), .RES(RES), .EN(EN), .DIR(DIR), .LOAD(LOAD), .LDVAL(LDVAL[15:0]), .DP(DP[3:0]),
    .Y(y0), .AN(an0), .CNT(cnt0), .WRAP(wrap0), .C(c0));
  count7seg_mux #(.DIGITS(4), .TICK_DIV(4), .SCAN_DIV(2), .BCD(1), .LZB(1), .ACTIVE_LOW(1)) u1 (
    .CLK(CLK), .RES(RES), .EN(EN), .DIR(DIR), .LOAD(LOAD), .LDVAL(LDVAL[15:0]), .DP(DP[3:0]),
    .Y(y1), .AN(an1), .CNT(cnt1), .WRAP(wrap1), .C(c1));
  count7seg_mux #(.DIGITS(2), .TICK_DIV(3), .SCAN_DIV(2), .BCD(0), .LZB(0), .ACTIVE_LOW(0)) u2 (
    .CLK(CLK), .RES(RES), .EN(EN), .DIR(DIR), .LOAD(LOAD), .LDVAL(LDVAL[7:0]), .DP(DP[1:0]),
    .Y(y2), .AN(an2), .CNT(cnt2), .WRAP(wrap2), .C(c2));
  count7seg_mux #(.DIGITS(4), .TICK_DIV(2), .SCAN_DIV(3), .BCD(0), .LZB(1), .ACTIVE_LOW(1)) u3 (
    .CLK(CLK), .RES(RES), .EN(EN), .DIR(DIR), .LOAD(LOAD), .LDVAL(LDVAL[15:0]), .DP(DP[3:0]),
    .Y(y3), .AN(an3), .CNT(cnt3), .WRAP(wrap3), .C(c3));

  // Instance configuration, same order as u0..u3.
  localparam int CD [4] = '{4, 4, 2, 4};
  localparam int CT [4] = '{4, 4, 3, 2};
  localparam int CS [4] = '{2, 2, 2, 3};
  localparam int CB [4] = '{1, 1, 0, 0};
  localparam int CL [4] = '{1, 1, 0, 1};
  localparam int CA [4] = '{0, 1, 0, 1};
  localparam logic [6:0] SEG [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011, 7'b1011011,
    7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

  logic [7:0]  o_y [4];
  logic [7:0]  o_an [4];
  logic [31:0] o_cnt [4];
  logic        o_wrap [4];
  logic        o_c [4];

  always_comb begin
    o_y[0] = y0;  o_y[1] = y1;  o_y[2] = y2;  o_y[3] = y3;
    o_an[0] = {4'b0, an0}; o_an[1] = {4'b0, an1}; o_an[2] = {6'b0, an2}; o_an[3] = {4'b0, an3};
    o_cnt[0] = {16'b0, cnt0}; o_cnt[1] = {16'b0, cnt1}; o_cnt[2] = {24'b0, cnt2}; o_cnt[3] = {16'b0, cnt3};
    o_wrap[0] = wrap0; o_wrap[1] = wrap1; o_wrap[2] = wrap2; o_wrap[3] = wrap3;
    o_c[0] = c0; o_c[1] = c1; o_c[2] = c2; o_c[3] = c3;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The counter is held as a plain number modulo base^DIGITS.
  longint     mv [4];
  int         mpre [4], mscan [4], midx [4];
  logic       mwrap [4];
  logic [7:0] my [4], man [4];

  function automatic longint pw(input longint b, input int e);
    longint r;
    r = 1;
    for (int i = 0; i < e; i++) r = r * b;
    return r;
  endfunction

  function automatic longint basev(input int k);
    return (CB[k] != 0) ? 10 : 16;
  endfunction

  function automatic int dig(input int k, input longint v, input int i);
    return int'((v / pw(basev(k), i)) % basev(k));
  endfunction

  function automatic logic [31:0] packv(input int k, input longint v);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < CD[k]; i++) r[4*i +: 4] = 4'(dig(k, v, i));
    return r;
  endfunction

  function automatic longint ldv(input int k, input logic [31:0] ld);
    longint v;
    int n;
    v = 0;
    for (int i = 0; i < CD[k]; i++) begin
      n = int'(ld[4*i +: 4]);
      if (CB[k] != 0 && n > 9) n = 9;
      v = v + longint'(n) * pw(basev(k), i);
    end
    return v;
  endfunction

  function automatic logic [7:0] mskv(input int k);
    return 8'((1 << CD[k]) - 1);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      mv[k] = 0; mpre[k] = 0; mscan[k] = 0; midx[k] = 0; mwrap[k] = 1'b0;
      my[k]  = (CA[k] != 0) ? ~8'hFC : 8'hFC;
      man[k] = (CA[k] != 0) ? (8'h01 ^ mskv(k)) : 8'h01;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 4; k++) begin
      longint b, m;
      bit blank;
      logic [7:0] y, an;
      b = basev(k);
      m = pw(b, CD[k]);
      blank = (CL[k] != 0) && (midx[k] > 0) && ((mv[k] / pw(b, midx[k])) == 0);
      y = {(blank ? 7'b0 : SEG[dig(k, mv[k], midx[k])]), DP[midx[k]]};
      an = 8'(1) << midx[k];
      if (CA[k] != 0) begin
        y  = ~y;
        an = an ^ mskv(k);
      end
      my[k] = y;
      man[k] = an;
      mwrap[k] = 1'b0;
      if (LOAD) begin
        mv[k] = ldv(k, LDVAL);
        mpre[k] = 0;
      end else if (EN) begin
        if (mpre[k] == CT[k] - 1) begin
          mpre[k] = 0;
          if (DIR) begin
            mwrap[k] = (mv[k] == m - 1);
            mv[k] = (mv[k] + 1) % m;
          end else begin
            mwrap[k] = (mv[k] == 0);
            mv[k] = (mv[k] + m - 1) % m;
          end
        end else begin
          mpre[k] = mpre[k] + 1;
        end
      end
      if (mscan[k] == CS[k] - 1) begin
        mscan[k] = 0;
        midx[k] = (midx[k] + 1) % CD[k];
      end else begin
        mscan[k] = mscan[k] + 1;
      end
    end
  endtask

  always @(posedge CLK or negedge RES) begin
    if (!RES) model_reset();
    else      model_step();
  end

  // Every cycle, every instance, every output against the model.
  always @(negedge CLK) begin
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("cnt%0d", k),  o_cnt[k], packv(k, mv[k]));
      chk($sformatf("wrap%0d", k), {31'b0, o_wrap[k]}, {31'b0, mwrap[k]});
      chk($sformatf("y%0d", k),    {24'b0, o_y[k]}, {24'b0, my[k]});
      chk($sformatf("an%0d", k),   {24'b0, o_an[k]}, {24'b0, man[k]});
      chk($sformatf("c%0d", k),    {31'b0, o_c[k]}, (CA[k] != 0) ? 32'd1 : 32'd0);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    logic [7:0] e0, e1;
    #1 RES = 1'b0;
    tick(3);
    chk("rst_cnt0", cnt0, 32'h0);
    chk("rst_y0", y0, 32'hFC);
    chk("rst_an0", an0, 32'h1);
    chk("rst_y1_al", y1, 32'h03);
    chk("rst_an1_al", an1, 32'hE);
    chk("rst_c1", c1, 32'h1);

    // count up from reset
    RES = 1'b1; EN = 1'b1; DIR = 1'b1;
    chk("start_cnt0", cnt0, 32'h0);
    tick(4);
    chk("cnt0_after4", cnt0, 32'h0001);
    tick(36);
    chk("cnt0_after40", cnt0, 32'h0010);
    chk("wrap0_quiet", wrap0, 32'h0);

    // wrap up from 9999, then down from 0000
    LOAD = 1'b1; LDVAL = 32'h9999;
    tick(1); LOAD = 1'b0;
    chk("ld9999", cnt0, 32'h9999);
    tick(3);
    chk("hold9999", cnt0, 32'h9999);
    tick(1);
    chk("wrapup_cnt", cnt0, 32'h0000);
    chk("wrapup_pulse", wrap0, 32'h1);
    tick(1);
    chk("wrapup_end", wrap0, 32'h0);
    DIR = 1'b0;
    tick(3);
    chk("wrapdn_cnt", cnt0, 32'h9999);
    chk("wrapdn_pulse", wrap0, 32'h1);
    tick(1);
    chk("wrapdn_end", wrap0, 32'h0);

    // BCD clamp vs hex load
    DIR = 1'b1; LOAD = 1'b1; LDVAL = 32'h12AB;
    tick(1); LOAD = 1'b0;
    chk("ld_bcd_clamp", cnt0, 32'h1299);
    chk("ld_hex", cnt3, 32'h12AB);
    chk("ld_hex2", cnt2, 32'hAB);
    tick(2);
    chk("hex_up", cnt3, 32'h12AC);

    // two-digit hex wrap
    LOAD = 1'b1; LDVAL = 32'h00FE;
    tick(1); LOAD = 1'b0;
    chk("ld_fe", cnt2, 32'hFE);
    tick(3);
    chk("up_ff", cnt2, 32'hFF);
    tick(3);
    chk("up_00", cnt2, 32'h00);
    chk("wrap2_pulse", wrap2, 32'h1);
    tick(1);
    chk("wrap2_end", wrap2, 32'h0);

    // leading-zero blanking with a decimal point on digit 2
    EN = 1'b0; DP = 8'b0100; LOAD = 1'b1; LDVAL = 32'h0007;
    tick(1); LOAD = 1'b0;
    tick(2);
    for (int i = 0; i < 8; i++) begin
      case (an0)
        4'b0001: e0 = 8'b11100000;
        4'b0010: e0 = 8'b00000000;
        4'b0100: e0 = 8'b00000001;
        4'b1000: e0 = 8'b00000000;
        default: e0 = 8'h55;
      endcase
      case (an1)
        4'b1110: e1 = ~8'b11100000;
        4'b1101: e1 = ~8'b00000000;
        4'b1011: e1 = ~8'b00000001;
        4'b0111: e1 = ~8'b00000000;
        default: e1 = 8'h55;
      endcase
      chk("lzb_y0", y0, e0);
      chk("lzb_y1_al", y1, e1);
      tick(1);
    end

    // asynchronous reset in mid-cycle
    EN = 1'b1; DP = 8'h00;
    @(posedge CLK); #3;
    RES = 1'b0;
    #1;
    chk("async_cnt0", cnt0, 32'h0);
    chk("async_wrap0", wrap0, 32'h0);
    chk("async_an0", an0, 32'h1);
    chk("async_y0", y0, 32'hFC);
    chk("async_cnt3", cnt3, 32'h0);
    tick(1);
    RES = 1'b1; DIR = 1'b1;
    tick(4);
    chk("resume_cnt0", cnt0, 32'h0001);

    // randomized traffic, occasional loads near the extremes and resets
    for (int i = 0; i < 3000; i++) begin
      @(posedge CLK); #1;
      EN = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 29) == 0) DIR = ~DIR;
      LOAD = ($urandom_range(0, 39) == 0);
      case ($urandom_range(0, 3))
        0: LDVAL = 32'hFFFF_FFFF;
        1: LDVAL = 32'h0;
        default: LDVAL = $urandom;
      endcase
      DP = 8'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        #2 RES = 1'b0;
        #4 RES = 1'b1;
      end
    end

    @(posedge CLK); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
